// File: rtl/uba_intr_arb.sv
// UBA interrupt arbiter: summarises device BR requests, raises KS10 PI requests,
// and on acknowledge fetches one winning device's vector with a fetch timeout.
module uba_intr_arb #(
  parameter int unsigned NDEV   = 4,
  parameter int unsigned ACKTMO = 31
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            statINI,
  input  logic [2:0]      statPIH,
  input  logic [2:0]      statPIL,
  input  logic [NDEV-1:0] devINTHI,
  input  logic [NDEV-1:0] devINTLO,
  input  logic            devVECTV,
  input  logic [15:0]     devVECT,
  input  logic            busACKI,
  input  logic [2:0]      busACKPI,
  output logic            statINTHI,
  output logic            statINTLO,
  output logic [6:0]      busINTR,
  output logic [NDEV-1:0] devACK,
  output logic            ackVALID,
  output logic [17:0]     ackVECT,
  output logic            setTMO
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_VECT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_cnt, w_cnt_nxt;
  logic [NDEV-1:0] r_devack, w_devack_nxt;
  logic            r_valid, w_valid_nxt;
  logic            r_tmo, w_tmo_nxt;
  logic [17:0]     r_vect, w_vect_nxt;
  logic            r_inthi, r_intlo;
  logic [6:0]      r_intr, w_intr;

  logic            w_anyhi, w_anylo;
  logic            w_hisel, w_losel;
  logic [NDEV-1:0] w_req, w_win;

  assign w_anyhi = |devINTHI;
  assign w_anylo = |devINTLO;

  // HI class takes precedence when both PI levels match the acknowledged level
  always_comb begin
    w_hisel = (statPIH == busACKPI) && w_anyhi;
    w_losel = !w_hisel && (statPIL == busACKPI) && w_anylo;
    if (w_hisel)      w_req = devINTHI;
    else if (w_losel) w_req = devINTLO;
    else              w_req = '0;
  end

  always_comb begin
    w_win = '0;
    for (int unsigned i = 0; i < NDEV; i++) begin
      if (w_req[i] && (w_win == '0)) w_win[i] = 1'b1;
    end
  end

  always_comb begin
    w_intr = '0;
    if ((statPIH != 3'd0) && w_anyhi) w_intr[statPIH - 3'd1] = 1'b1;
    if ((statPIL != 3'd0) && w_anylo) w_intr[statPIL - 3'd1] = 1'b1;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_devack_nxt = r_devack;
    w_valid_nxt  = 1'b0;
    w_tmo_nxt    = 1'b0;
    w_vect_nxt   = '0;
    case (r_state)
      S_IDLE: begin
        if (busACKI && (busACKPI != 3'd0) && (w_hisel || w_losel)) begin
          w_devack_nxt = w_win;
          w_cnt_nxt    = 8'(ACKTMO);
          w_state_nxt  = S_VECT;
        end
      end
      S_VECT: begin
        if (!busACKI) begin
          w_devack_nxt = '0;
          w_state_nxt  = S_IDLE;
        end else if (devVECTV) begin
          w_valid_nxt  = 1'b1;
          w_vect_nxt   = {2'b00, devVECT};
          w_devack_nxt = '0;
          w_state_nxt  = S_DONE;
        end else if (r_cnt == 8'd1) begin
          w_valid_nxt  = 1'b1;
          w_tmo_nxt    = 1'b1;
          w_devack_nxt = '0;
          w_state_nxt  = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_DONE: begin
        if (!busACKI) w_state_nxt = S_IDLE;
      end
      default: begin
        w_devack_nxt = '0;
        w_state_nxt  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || statINI) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_devack <= '0;
      r_valid  <= 1'b0;
      r_tmo    <= 1'b0;
      r_vect   <= '0;
      r_inthi  <= 1'b0;
      r_intlo  <= 1'b0;
      r_intr   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_devack <= w_devack_nxt;
      r_valid  <= w_valid_nxt;
      r_tmo    <= w_tmo_nxt;
      r_vect   <= w_vect_nxt;
      r_inthi  <= w_anyhi;
      r_intlo  <= w_anylo;
      r_intr   <= w_intr;
    end
  end

  assign statINTHI = r_inthi;
  assign statINTLO = r_intlo;
  assign busINTR   = r_intr;
  assign devACK    = r_devack;
  assign ackVALID  = r_valid;
  assign ackVECT   = r_vect;
  assign setTMO    = r_tmo;

endmodule
